key_seq_port: RTL
=================

# key_seq_port

Bus-mapped challenge/sequence responder for the 93xx CPU board's I/O window. It is the parametrised successor to the fixed 6-bit registered key sequencer. Probe reads carry a code in the address field. A run of UNLOCK_LEN correct probes unlocks the block; after that each read returns bits from a maximal-length LFSR. State width, key, window decode and output width are generics, and a write to the window relocks the block.

## Interface
- STATE_W, 6: LFSR / state register width (≥ PROBE_W, ≥ DATA_W).
- TAPS, 6'h30: LFSR feedback mask (x^6+x^5+1).
- SEED, 6'h01: reset/relock state value; must be non-zero.
- KEY, 4'hA: XOR key applied to expected probe code.
- PROBE_W, 4: probe field width.
- PROBE_LSB, 4: probe field position in `ba`.
- UNLOCK_LEN, 4: consecutive correct probes required (1..255).
- ADDR_W, 14: bus address width.
- WIN_W, 2: number of top address bits decoded.
- WIN_VAL, 2'b01: required value of `ba[ADDR_W-1 -: WIN_W]`.
- DATA_W, 2: read data width.
- clk  in  1  bus clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sel_n  in  1  active-low device select.
- ba  in  ADDR_W  bus address.
- br_w  in  1  1 = read, 0 = write.
- rd_stb  in  1  one-cycle access strobe; one strobe per bus access.
- rd_data  out  DATA_W  read data, valid while `rd_oe`=1.
- rd_oe  out  1  drive enable for external tristate.
- unlocked  out  1  registered unlock status.
- state_q  out  STATE_W  current LFSR state (debug).

## Operation
- Window hit: `hit` = ~sel_n & (ba top WIN_W bits == WIN_VAL).
- Probe: `probe` = ba[PROBE_LSB +: PROBE_W]. Expected value: `exp` = state_q[PROBE_W-1:0] ^ KEY.
- LFSR step: `fb` = ^(state_q & TAPS), forced to 1 if state_q==0. Next state = {state_q[STATE_W-2:0], fb}.
- FSM states:
  - SEEK (reset state).
    - rd_stb & hit & br_w & probe==exp: step LFSR and increment cnt. If cnt reaches UNLOCK_LEN, go to OPEN and set `unlocked`=1.
    - rd_stb & hit & br_w & probe!=exp: state_q←SEED, cnt←0.
  - OPEN.
    - rd_stb & hit & br_w: step LFSR; probe value is ignored.
- Relock: rd_stb & hit & ~br_w, in either state, gives state_q←SEED, cnt←0, FSM←SEEK, unlocked←0.
- rd_stb without hit: no state change.
- rd_data:
  - OPEN: state_q[STATE_W-1 -: DATA_W].
  - SEEK: all zeros.
- rd_oe = rst_n & hit & br_w (combinational; no strobe needed).
- cnt width is clog2(UNLOCK_LEN+1) and saturates; it is never observed above UNLOCK_LEN.

## Timing
- Reset (async assert, sync release): state_q=SEED, cnt=0, FSM=SEEK, unlocked=0, rd_data=0, rd_oe=0.
- rd_data and rd_oe are combinational from registered state and the current bus inputs. The data returned by a read reflects the state *before* that read's clock edge.
- State, cnt and unlocked update on the clk edge where rd_stb=1. `unlocked` rises on the same edge as the final correct probe.
- Back-to-back strobes on consecutive cycles are legal; each one is a separate access.
- If rst_n asserts mid-access, the block returns to reset values immediately and rd_oe drops with it.

## Configuration
- `KEYSEQ_AUTOLOCK_EN` defined: in OPEN, a step whose next state equals SEED also moves FSM to SEEK and clears unlocked and cnt on the same edge. With defaults this happens after one full 63-read period.
- `KEYSEQ_AUTOLOCK_EN` undefined: OPEN is sticky until a window write or reset.

## Test plan
All cases use default parameters; "probe" means a read with ba=0x1000|(code<<4), br_w=1, sel_n=0.
- Reset, then idle bus -> state_q=0x01, unlocked=0, rd_oe=0. A read probe raises rd_oe with rd_data=2'b00.
- Probes B, 8, E, 2 -> state_q steps 0x02, 0x04, 0x08, 0x10; unlocked=1 after the 4th edge.
- Probes B, 8, then 0 -> state_q=0x01 and cnt=0 after the third edge; unlocked stays 0.
- When unlocked at 0x10, two reads -> rd_data 2'b01 then 2'b10; state_q goes 0x21, then 0x03.
- When unlocked, a write to 0x1000 -> state_q=0x01, unlocked=0; a subsequent read gives rd_data=0. An access with sel_n=1 or ba=0x2000 changes nothing.
- With `KEYSEQ_AUTOLOCK_EN`, unlock and then 63 reads -> unlocked falls on the read whose next state is 0x01. Without the macro it stays 1.

Source files
------------

// File: rtl/key_seq_port.sv
// rtl/key_seq_port.sv - bus-mapped probe/unlock sequencer returning LFSR bits once unlocked.
// Optional `KEYSEQ_AUTOLOCK_EN: relock automatically when the LFSR wraps back to SEED.
module key_seq_port #(
  parameter int                   STATE_W    = 6,
  parameter logic [STATE_W-1:0]   TAPS       = 6'h30,
  parameter logic [STATE_W-1:0]   SEED       = 6'h01,
  parameter int                   PROBE_W    = 4,
  parameter logic [PROBE_W-1:0]   KEY        = 4'hA,
  parameter int                   PROBE_LSB  = 4,
  parameter int                   UNLOCK_LEN = 4,
  parameter int                   ADDR_W     = 14,
  parameter int                   WIN_W      = 2,
  parameter logic [WIN_W-1:0]     WIN_VAL    = 2'b01,
  parameter int                   DATA_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel_n,
  input  logic [ADDR_W-1:0]  ba,
  input  logic               br_w,
  input  logic               rd_stb,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_oe,
  output logic               unlocked,
  output logic [STATE_W-1:0] state_q
);

  localparam int CNT_W = $clog2(UNLOCK_LEN + 1);

  typedef enum logic {SEEK, OPEN} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               unlocked_q, unlocked_d;
  logic [STATE_W-1:0] state_d, lfsr_next;
  logic               hit, fb;
  logic [PROBE_W-1:0] probe, exp_code;
  logic               unused_ba;

  assign unused_ba = ^ba;

  assign hit       = ~sel_n & (ba[ADDR_W-1 -: WIN_W] == WIN_VAL);
  assign probe     = ba[PROBE_LSB +: PROBE_W];
  assign exp_code  = state_q[PROBE_W-1:0] ^ KEY;
  // All-zero state would lock the LFSR up, so feedback is forced high there.
  assign fb        = (state_q == '0) ? 1'b1 : ^(state_q & TAPS);
  assign lfsr_next = {state_q[STATE_W-2:0], fb};
  assign cnt_inc   = (cnt_q == CNT_W'(UNLOCK_LEN)) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    unlocked_d = unlocked_q;
    state_d    = state_q;
    if (rd_stb && hit) begin
      if (!br_w) begin
        fsm_d      = SEEK;
        cnt_d      = '0;
        unlocked_d = 1'b0;
        state_d    = SEED;
      end else begin
        case (fsm_q)
          SEEK: begin
            if (probe == exp_code) begin
              state_d = lfsr_next;
              cnt_d   = cnt_inc;
              if (cnt_inc == CNT_W'(UNLOCK_LEN)) begin
                fsm_d      = OPEN;
                unlocked_d = 1'b1;
              end
            end else begin
              state_d = SEED;
              cnt_d   = '0;
            end
          end
          OPEN: begin
            state_d = lfsr_next;
`ifdef KEYSEQ_AUTOLOCK_EN
            if (lfsr_next == SEED) begin
              fsm_d      = SEEK;
              cnt_d      = '0;
              unlocked_d = 1'b0;
            end
`endif
          end
          default: fsm_d = SEEK;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= SEEK;
      cnt_q      <= '0;
      unlocked_q <= 1'b0;
      state_q    <= SEED;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      unlocked_q <= unlocked_d;
      state_q    <= state_d;
    end
  end

  assign unlocked = unlocked_q;
  assign rd_oe    = rst_n & hit & br_w;
  assign rd_data  = (fsm_q == OPEN) ? state_q[STATE_W-1 -: DATA_W] : '0;

endmodule
